clk_div_monitor: RTL and testbench
==================================

CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of all cycle counters and measurement outputs.
REQ-002 Parameter EXP_PERIOD, default 10: expected sigIN period in clkIN cycles.
REQ-003 Parameter EXP_HIGH, default 4: expected sigIN high time in clkIN cycles.
REQ-004 Parameter TOL, default 0: allowed absolute deviation for period and high time, in cycles.
REQ-005 Parameter LOCK_CNT, default 4: consecutive matching periods required for lock.
REQ-006 Parameter TIMEOUT, default 32: clkIN cycles without a detected rise that count as signal loss; TIMEOUT < 2^CNT_W - 1.
REQ-007 clkIN  input  1  the only clock; all logic on its rising edge.
REQ-008 rstIN  input  1  reset; synchronous, active-high.
REQ-009 sigIN  input  1  divided clock under test; asynchronous to clkIN.
REQ-010 rise  output  1  one-cycle pulse per detected sigIN rising edge.
REQ-011 fall  output  1  one-cycle pulse per detected sigIN falling edge.
REQ-012 period  output  CNT_W  last measured rise-to-rise interval in clkIN cycles.
REQ-013 highTime  output  CNT_W  last measured rise-to-fall interval in clkIN cycles.
REQ-014 measValid  output  1  one-cycle pulse when period and highTime have been updated.
REQ-015 locked  output  1  level; high while the sigIN frequency is confirmed.
REQ-016 lossErr  output  1  one-cycle pulse when lock is lost through mismatch or timeout.
REQ-017 timeout  output  1  one-cycle pulse when no rise is seen for TIMEOUT cycles.

Function
REQ-018 sigIN SHALL pass through a 2-flop synchronizer (s1, s2) followed by a history flop (s3).
REQ-019 rise SHALL be registered from (s2 & ~s3) and fall from (~s2 & s3), which gives a fixed latency of 3 clkIN edges from the first edge sampling the new sigIN level.
REQ-020 Counter perCnt SHALL load 1 on rise, otherwise increment, and saturate at 2^CNT_W-1.
REQ-021 Counter hiCnt SHALL load 1 on rise, increment while s3 is high, and hold while s3 is low.
REQ-022 On fall, highTime SHALL load hiCnt.
REQ-023 On rise in states MEAS or LOCK, period SHALL load perCnt and measValid SHALL pulse in the same cycle.
REQ-024 A period match SHALL mean |period_new - EXP_PERIOD| <= TOL and |highTime - EXP_HIGH| <= TOL, evaluated on the rise cycle using the new period value.
REQ-025 FSM states: IDLE, MEAS, LOCK.
REQ-026 IDLE: on the first rise, go to MEAS with goodCnt = 0; do not update period and do not pulse measValid.
REQ-027 MEAS: a match increments goodCnt; a mismatch clears it; when goodCnt reaches LOCK_CNT, go to LOCK.
REQ-028 LOCK: a match holds the state; a mismatch pulses lossErr, clears goodCnt and returns to MEAS.
REQ-029 locked SHALL equal (state == LOCK), registered.
REQ-030 Timeout: when perCnt reaches TIMEOUT in MEAS or LOCK without a rise, pulse timeout and go to IDLE; also pulse lossErr if the state was LOCK.
REQ-031 Timeout SHALL NOT fire in IDLE.
REQ-032 Simultaneous rise and timeout condition: the rise SHALL win and timeout SHALL NOT pulse.
REQ-033 Measured values SHALL wrap nowhere: counters saturate, and a saturated period is a mismatch.
REQ-034 rise and fall SHALL never be high in the same cycle.

Reset
REQ-035 While rstIN is high at a clkIN edge: state = IDLE; s1, s2, s3, perCnt, hiCnt, goodCnt, period and highTime = 0; all outputs = 0.
REQ-036 Reset mid-operation SHALL discard any measurement in progress; the first rise after reset is treated as the IDLE first rise.

Verification
REQ-037 sigIN from a divide-by-10 source (4 high, 6 low) with defaults -> period = 10, highTime = 4, measValid every 10 cycles, locked rises on the 4th measValid.
REQ-038 Locked, then one period stretched to 11 -> lossErr pulse, locked = 0, period = 11; relock after 4 further good periods.
REQ-039 Locked, then sigIN held low -> timeout pulse and lossErr pulse 32 cycles after the last perCnt load, state IDLE, locked = 0.
REQ-040 TOL = 1 with alternating periods of 9 and 11 (high time 4) -> lock achieved; the same stimulus with TOL = 0 -> locked never asserts.
REQ-041 rstIN asserted for 1 cycle while locked -> next cycle all outputs 0; the first rise afterwards gives no measValid.
REQ-042 Single sigIN toggle -> rise appears exactly 3 clkIN edges after sampling, fall likewise, and they are never coincident.

Source files
------------

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures period and high time of a divided clock, checks them against expected values, tracks lock
module clk_div_monitor #(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 10,
    parameter int EXP_HIGH   = 4,
    parameter int TOL        = 0,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 32
) (
    input  logic             clkIN,
    input  logic             rstIN,
    input  logic             sigIN,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] highTime,
    output logic             measValid,
    output logic             locked,
    output logic             lossErr,
    output logic             timeout
);
    typedef enum logic [1:0] {IDLE, MEAS, LOCK} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    state_t state;
    logic s1, s2, s3, riseDet, fallDet, match, timeHit;
    logic [CNT_W-1:0] perCnt, hiCnt, goodCnt;
    int perDiff, hiDiff;
    // edge detect, window check against the fresh period, and the no-rise timeout condition
    always_comb begin
        riseDet = s2 & ~s3;
        fallDet = ~s2 & s3;
        perDiff = int'(perCnt) - EXP_PERIOD;
        hiDiff  = int'(highTime) - EXP_HIGH;
        match   = (perCnt != CNT_MAX) && (perDiff <= TOL) && (perDiff >= -TOL) && (hiDiff <= TOL) && (hiDiff >= -TOL);
        timeHit = (state != IDLE) && !riseDet && (perCnt == CNT_W'(TIMEOUT));
    end
    // synchronizer, history flop and registered edge pulses
    always_ff @(posedge clkIN) begin
        if (rstIN) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= sigIN;
            s2   <= s1;
            s3   <= s2;
            rise <= riseDet;
            fall <= fallDet;
        end
    end
    // saturating period and high-time counters; high time captured on each fall
    always_ff @(posedge clkIN) begin
        if (rstIN) begin
            perCnt   <= '0;
            hiCnt    <= '0;
            highTime <= '0;
        end else begin
            perCnt <= riseDet ? CNT_ONE : (perCnt == CNT_MAX) ? perCnt : perCnt + CNT_ONE;
            hiCnt  <= riseDet ? CNT_ONE : (s3 && hiCnt != CNT_MAX) ? hiCnt + CNT_ONE : hiCnt;
            if (fallDet)
                highTime <= hiCnt;
        end
    end
    // lock FSM; a rise always takes priority over the timeout
    always_ff @(posedge clkIN) begin
        if (rstIN) begin
            state     <= IDLE;
            goodCnt   <= '0;
            period    <= '0;
            measValid <= 1'b0;
            locked    <= 1'b0;
            lossErr   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            measValid <= 1'b0;
            lossErr   <= 1'b0;
            timeout   <= 1'b0;
            if (riseDet && state == IDLE) begin
                state   <= MEAS;
                goodCnt <= '0;
                locked  <= 1'b0;
            end else if (riseDet) begin
                period    <= perCnt;
                measValid <= 1'b1;
                if (match && state == LOCK) begin
                    locked <= 1'b1;
                end else if (match && goodCnt == CNT_W'(LOCK_CNT - 1)) begin
                    state   <= LOCK;
                    goodCnt <= goodCnt + CNT_ONE;
                    locked  <= 1'b1;
                end else if (match) begin
                    goodCnt <= goodCnt + CNT_ONE;
                end else begin
                    lossErr <= (state == LOCK);
                    state   <= MEAS;
                    goodCnt <= '0;
                    locked  <= 1'b0;
                end
            end else if (timeHit) begin
                timeout <= 1'b1;
                lossErr <= (state == LOCK);
                state   <= IDLE;
                goodCnt <= '0;
                locked  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: directed stimulus against an event-time model of the monitor, for TOL=0 and TOL=1 instances
module tb_clk_div_monitor;
    localparam int W = 8, EP = 10, EH = 4, LC = 4, TO = 32, SAT = 255;
    localparam int M_IDLE = 0, M_MEAS = 1, M_LOCK = 2;
    logic clk = 1'b0, rst = 1'b1, sig = 1'b0;
    logic riseO[2], fallO[2], mvO[2], lkO[2], leO[2], toO[2];
    logic [W-1:0] perO[2], htO[2];
    int checks = 0, errors = 0;
    int n = 0, lastReset = 0, lastRise = 0;
    bit smp[0:8191];
    bit eRise, eFall;
    int eHt;
    int mode[2], streak[2], ePer[2];
    bit eMv[2], eLk[2], eLe[2], eTo[2];
    int tolv[2] = '{0, 1};
    int mvCount = 0, leCount = 0, toCount = 0, lkCount = 0;

    always #5 clk = ~clk;

    clk_div_monitor #(.CNT_W(W), .EXP_PERIOD(EP), .EXP_HIGH(EH), .TOL(0), .LOCK_CNT(LC), .TIMEOUT(TO)) dut0 (
        .clkIN(clk), .rstIN(rst), .sigIN(sig), .rise(riseO[0]), .fall(fallO[0]), .period(perO[0]),
        .highTime(htO[0]), .measValid(mvO[0]), .locked(lkO[0]), .lossErr(leO[0]), .timeout(toO[0]));
    clk_div_monitor #(.CNT_W(W), .EXP_PERIOD(EP), .EXP_HIGH(EH), .TOL(1), .LOCK_CNT(LC), .TIMEOUT(TO)) dut1 (
        .clkIN(clk), .rstIN(rst), .sigIN(sig), .rise(riseO[1]), .fall(fallO[1]), .period(perO[1]),
        .highTime(htO[1]), .measValid(mvO[1]), .locked(lkO[1]), .lossErr(leO[1]), .timeout(toO[1]));

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, n, got, exp);
        end
    endtask

    function automatic bit v(input int k);
        return (k > lastReset) ? smp[k] : 1'b0;
    endfunction

    function automatic int absd(input int a);
        return (a < 0) ? -a : a;
    endfunction

    // model: sigIN level seen 3 edges late; measurements are edge-time differences
    task automatic step(input bit s, input bit r);
        int p;
        bit ok;
        n++;
        smp[n] = s;
        if (r) begin
            lastReset = n;
            eRise = 0;
            eFall = 0;
            eHt = 0;
            for (int i = 0; i < 2; i++) begin
                mode[i] = M_IDLE; streak[i] = 0; ePer[i] = 0;
                eMv[i] = 0; eLk[i] = 0; eLe[i] = 0; eTo[i] = 0;
            end
        end else begin
            eRise = v(n - 2) && !v(n - 3);
            eFall = !v(n - 2) && v(n - 3);
            p = (n - lastRise > SAT) ? SAT : n - lastRise;
            for (int i = 0; i < 2; i++) begin
                eMv[i] = 0; eLe[i] = 0; eTo[i] = 0;
                if (eRise && mode[i] == M_IDLE) begin
                    mode[i] = M_MEAS;
                    streak[i] = 0;
                end else if (eRise) begin
                    ePer[i] = p;
                    eMv[i] = 1;
                    ok = (p != SAT) && absd(p - EP) <= tolv[i] && absd(eHt - EH) <= tolv[i];
                    if (ok && mode[i] == M_MEAS) begin
                        streak[i]++;
                        if (streak[i] == LC) mode[i] = M_LOCK;
                    end else if (!ok) begin
                        eLe[i] = (mode[i] == M_LOCK);
                        mode[i] = M_MEAS;
                        streak[i] = 0;
                    end
                end else if (mode[i] != M_IDLE && n - lastRise == TO) begin
                    eTo[i] = 1;
                    eLe[i] = (mode[i] == M_LOCK);
                    mode[i] = M_IDLE;
                    streak[i] = 0;
                end
                eLk[i] = (mode[i] == M_LOCK);
            end
            if (eRise) lastRise = n;
            if (eFall) eHt = p;
        end
    endtask

    // every cycle: advance the model on the rising edge, compare on the falling edge
    initial begin
        forever begin
            @(posedge clk);
            step(sig, rst);
            @(negedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rise%0d", i), riseO[i], eRise);
                chk($sformatf("fall%0d", i), fallO[i], eFall);
                chk($sformatf("period%0d", i), perO[i], ePer[i]);
                chk($sformatf("highTime%0d", i), htO[i], eHt);
                chk($sformatf("measValid%0d", i), mvO[i], eMv[i]);
                chk($sformatf("locked%0d", i), lkO[i], eLk[i]);
                chk($sformatf("lossErr%0d", i), leO[i], eLe[i]);
                chk($sformatf("timeout%0d", i), toO[i], eTo[i]);
                chk($sformatf("rise_and_fall%0d", i), riseO[i] & fallO[i], 0);
            end
            mvCount += int'(mvO[0]);
            leCount += int'(leO[0]);
            toCount += int'(toO[0]);
            lkCount += int'(lkO[0]);
        end
    end

    task automatic cyc(input bit s);
        @(negedge clk);
        sig = s;
    endtask

    task automatic wave(input int hi, input int per);
        repeat (hi) cyc(1'b1);
        repeat (per - hi) cyc(1'b0);
    endtask

    initial begin
        int snap, tk0, tk1, le1k;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_period", perO[0], 0);
        chk("rst_highTime", htO[0], 0);
        chk("rst_locked", lkO[0], 0);
        chk("rst_measValid", mvO[0], 0);
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("latency_rise", riseO[0], int'(k == 3));
            chk("latency_fall", fallO[0], int'(k == 7));
            sig = (k <= 3);
        end
        cyc(1'b0);
        repeat (3) wave(4, 10);
        chk("lock_after_3", lkO[0], 0);
        wave(4, 10);
        chk("lock_after_4", lkO[0], 1);
        chk("lock_period", perO[0], 10);
        chk("lock_highTime", htO[0], 4);
        chk("lock_mv_count", mvCount, 4);
        wave(4, 11);
        wave(4, 10);
        chk("stretch_period", perO[0], 11);
        chk("stretch_unlock", lkO[0], 0);
        chk("stretch_loss_count", leCount, 1);
        chk("stretch_tol1_locked", lkO[1], 1);
        repeat (3) wave(4, 10);
        chk("relock_after_3", lkO[0], 0);
        wave(4, 10);
        chk("relock_after_4", lkO[0], 1);
        @(negedge clk);
        rst = 1'b1;
        sig = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_locked0", lkO[0], 0);
        chk("rst_mid_locked1", lkO[1], 0);
        chk("rst_mid_period", perO[0], 0);
        chk("rst_mid_highTime", htO[0], 0);
        chk("rst_mid_measValid", mvO[0], 0);
        snap = mvCount;
        wave(4, 10);
        chk("rst_first_rise_no_mv", mvCount - snap, 0);
        snap = lkCount;
        repeat (6) begin
            wave(4, 9);
            wave(4, 11);
        end
        chk("alt_tol1_locked", lkO[1], 1);
        chk("alt_tol0_never_locked", lkCount - snap, 0);
        tk0 = -1;
        tk1 = -1;
        le1k = -1;
        cyc(1'b1);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (toO[0] && tk0 < 0) tk0 = k;
            if (toO[1] && tk1 < 0) tk1 = k;
            if (leO[1] && le1k < 0) le1k = k;
            sig = (k <= 3);
        end
        chk("timeout_latency0", tk0, 35);
        chk("timeout_latency1", tk1, 35);
        chk("timeout_loss1", le1k, 35);
        chk("timeout_unlocked1", lkO[1], 0);
        snap = toCount;
        wave(4, 10);
        wave(4, 32);
        wave(4, 10);
        chk("rise_beats_timeout_period", perO[0], 32);
        chk("rise_beats_timeout_count", toCount - snap, 0);
        wave(300, 310);
        chk("highTime_saturates", htO[0], 255);
        repeat (4) cyc(1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end
endmodule
